// File: rtl/xc_sha256_pkg.sv
// Shared SHA-256 constants: sigma rotate/shift amounts, block geometry and the
// message-schedule sequencer state encoding.
package xc_sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;

    // sigma0: ROR 7, ROR 18, SHR 3
    localparam int S0_ROR_A = 7;
    localparam int S0_ROR_B = 18;
    localparam int S0_SHR   = 3;

    // sigma1: ROR 17, ROR 19, SHR 10
    localparam int S1_ROR_A = 17;
    localparam int S1_ROR_B = 19;
    localparam int S1_SHR   = 10;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    function automatic logic [WORD_W-1:0] ror32(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/xc_sha256_msched_if.sv
// Word-stream interface of the message-schedule sequencer: block words in,
// schedule words out, each under its own valid/ready pair.
interface xc_sha256_msched_if;
    import xc_sha256_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic [5:0]        out_index;
    logic              out_last;

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_index, out_last
    );

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_index, out_last
    );

endinterface

// File: rtl/xc_sha256_sigma.sv
// Combinational SHA-256 small-sigma unit; the same definition backs the
// xc.sha256.s0/s1 instruction datapath.
module xc_sha256_sigma
    import xc_sha256_pkg::*;
(
    input  logic [WORD_W-1:0] x_i,
    output logic [WORD_W-1:0] s0_o,
    output logic [WORD_W-1:0] s1_o
);

    assign s0_o = ror32(x_i, S0_ROR_A) ^ ror32(x_i, S0_ROR_B) ^ (x_i >> S0_SHR);
    assign s1_o = ror32(x_i, S1_ROR_A) ^ ror32(x_i, S1_ROR_B) ^ (x_i >> S1_SHR);

endmodule

// File: rtl/xc_sha256_msched.sv
// SHA-256 message-schedule sequencer: loads 16 words, then streams W[0..ROUNDS-1]
// expanding in place inside a 16-entry circular buffer.
module xc_sha256_msched
    import xc_sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic                g_clk,
    input  logic                g_resetn,
    input  logic                flush,
    output logic                busy,
    xc_sha256_msched_if.slave   bus
);

    localparam logic [3:0] LCNT_LAST = 4'(BLOCK_WORDS - 1);
    localparam logic [5:0] T_LAST    = 6'(ROUNDS - 1);

    state_e            state_q, state_d;
    logic [3:0]        lcnt_q, lcnt_d;
    logic [5:0]        t_q, t_d;
    logic [WORD_W-1:0] wbuf_q [BLOCK_WORDS];

    logic              buf_we;
    logic [3:0]        buf_waddr;
    logic [WORD_W-1:0] buf_wdata;

    logic [3:0]        idx_t, idx_m2, idx_m7, idx_m15;
    logic [WORD_W-1:0] s0_val, s1_val, s0_unused, s1_unused;
    logic [WORD_W-1:0] expanded, sched_word;
    logic              is_expand, emit;

    // Circular indices wrap mod 16; (t-15) mod 16 == (t+1) mod 16.
    assign idx_t   = t_q[3:0];
    assign idx_m2  = idx_t - 4'd2;
    assign idx_m7  = idx_t - 4'd7;
    assign idx_m15 = idx_t + 4'd1;

    xc_sha256_sigma u_sigma_s0 (
        .x_i  (wbuf_q[idx_m15]),
        .s0_o (s0_val),
        .s1_o (s1_unused)
    );

    xc_sha256_sigma u_sigma_s1 (
        .x_i  (wbuf_q[idx_m2]),
        .s0_o (s0_unused),
        .s1_o (s1_val)
    );

    assign expanded   = s1_val + wbuf_q[idx_m7] + s0_val + wbuf_q[idx_t];
    assign is_expand  = (t_q[5:4] != 2'b00);
    assign sched_word = is_expand ? expanded : wbuf_q[idx_t];
    assign emit       = (state_q == ST_EMIT);

    assign bus.in_ready  = !emit;
    assign bus.out_valid = emit;
    assign bus.out_word  = emit ? sched_word : '0;
    assign bus.out_index = emit ? t_q : '0;
    assign bus.out_last  = emit && (t_q == T_LAST);
    assign busy          = !((state_q == ST_LOAD) && (lcnt_q == 4'd0));

    always_comb begin
        state_d   = state_q;
        lcnt_d    = lcnt_q;
        t_d       = t_q;
        buf_we    = 1'b0;
        buf_waddr = lcnt_q;
        buf_wdata = bus.in_word;

        // flush discards any handshake in the same cycle, including the buffer write
        if (flush) begin
            state_d = ST_LOAD;
            lcnt_d  = 4'd0;
            t_d     = 6'd0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        buf_we    = 1'b1;
                        buf_waddr = lcnt_q;
                        buf_wdata = bus.in_word;
                        if (lcnt_q == LCNT_LAST) begin
                            state_d = ST_EMIT;
                            lcnt_d  = 4'd0;
                            t_d     = 6'd0;
                        end else begin
                            lcnt_d = lcnt_q + 4'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        buf_we    = is_expand;
                        buf_waddr = idx_t;
                        buf_wdata = expanded;
                        if (t_q == T_LAST) begin
                            state_d = ST_LOAD;
                            lcnt_d  = 4'd0;
                            t_d     = 6'd0;
                        end else begin
                            t_d = t_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                    lcnt_d  = 4'd0;
                    t_d     = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_LOAD;
            lcnt_q  <= 4'd0;
            t_q     <= 6'd0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            t_q     <= t_d;
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge g_clk) begin
        if (buf_we) begin
            wbuf_q[buf_waddr] <= buf_wdata;
        end
    end

endmodule

// File: doc/xc_sha256_msched.md
Name: xc_sha256_msched

Overview:
- SHA-256 message-schedule sequencer for the XCrypto SHA-256 path.
- Accepts one 512-bit block as 16 big-endian 32-bit words, then emits W[0..ROUNDS-1] in order to the round engine under valid/ready.
- Expanded words are computed with the shared sigma0/sigma1 functions, the same ones the xc.sha256.s0/s1 instructions use.
- Expansion uses a 16-entry circular buffer that is updated in place.

Parameters:
- ROUNDS, 64, number of words emitted per block; legal range 16..64.

Ports:
- g_clk  in  1  clock; all state changes on its rising edge.
- g_resetn  in  1  reset; asynchronous assertion, active-low.
- flush  in  1  synchronous abort; returns the block to LOAD.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block accepts in_word this cycle.
- in_word  in  32  message word; words are presented in order W0..W15.
- out_valid  out  1  out_word/out_index are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_word  out  32  schedule word W[t].
- out_index  out  6  t.
- out_last  out  1  high when t == ROUNDS-1.
- busy  out  1  high unless in LOAD with load count 0.

Behaviour:
- Clock and reset: one clock, g_clk. Reset g_resetn is asynchronous and active-low.
- State on reset: LOAD, lcnt=0, t=0, out_valid=0, in_ready=1, busy=0.
  - Buffer buf[0..15] is not reset; its contents are don't-care.
  - out_word, out_index and out_last are forced to 0 whenever out_valid=0.
- FSM has two states, LOAD and EMIT.
- LOAD:
  - in_ready=1, out_valid=0.
  - Each in_valid&in_ready handshake writes buf[lcnt] <= in_word, then lcnt++.
  - The handshake with lcnt==15 moves to EMIT, with t=0 and lcnt=0.
  - out_valid rises the cycle after the 16th accept.
- EMIT:
  - in_ready=0 and out_valid=1; output is combinational from buf and t.
  - t<16: out_word = buf[t].
  - t>=16: out_word = s1(buf[(t-2)%16]) + buf[(t-7)%16] + s0(buf[(t-15)%16]) + buf[t%16], mod 2^32.
    - s0(x) = ROR(x,7) ^ ROR(x,18) ^ SHR(x,3).
    - s1(x) = ROR(x,17) ^ ROR(x,19) ^ SHR(x,10).
  - On each out_valid&out_ready handshake:
    - if t>=16, write buf[t%16] <= out_word;
    - then t++.
  - The handshake with t==ROUNDS-1 returns the block to LOAD, with lcnt=0 and t=0.
  - out_valid falls the next cycle; in_ready rises the next cycle.
- Backpressure: while out_ready=0, out_word/out_index/out_last hold stable and no state changes.
- Throughput: one word per cycle when out_ready stays high. A block occupies 16 + ROUNDS cycles minimum.
- flush has priority over every handshake that cycle:
  - next state LOAD, lcnt=0, t=0;
  - no buffer write;
  - a concurrent input or output handshake is discarded.
- Reset mid-LOAD or mid-EMIT: immediate return to the reset state. No partial output follows.
- Width rules:
  - All adds are 32-bit and wrap; no carry out.
  - The t%16 index is t[3:0].
- ROUNDS==16: no expansion is performed; only buf words are emitted.

Decomposition:
- Shared package xc_sha256_pkg holds:
  - the ROR/SHR rotation constants (7, 18, 3, 17, 19, 10);
  - the state encoding (LOAD, EMIT);
  - the block word count (16).
- Sub-module xc_sha256_sigma: a combinational unit taking x and producing s0(x) and s1(x).
  - The same unit also backs the xc.sha256.s0/s1 instruction datapath, so both paths share one definition.
- The controller instantiates two sigma units: one for the s0 operand and one for the s1 operand.

Test Plan:
- Load the "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1.
  - Expect W0..W15 echoed in order, W16=0x61626380, W17=0x000F0000.
  - W18..W63 match the software model.
  - out_last is high only at index 63.
  - The first out_valid comes 1 cycle after the 16th accept.
- All sixteen words 0xFFFFFFFF -> W16=0x203FFFFC, checking 32-bit wraparound and the shift/rotate paths.
- Random block with random out_ready backpressure (about 50% duty):
  - output sequence identical to the no-stall run;
  - out_word and out_index stable while stalled;
  - in_ready=0 throughout EMIT.
- Assert flush at t=30 during a handshake -> no further outputs; in_ready=1 next cycle. A fresh block then loads and emits correct W0..W63.
- Drop g_resetn mid-LOAD (lcnt=9), then release and load a full block -> the first 9 stale words are ignored and the output matches the new block.
- Back-to-back blocks, with in_valid held high into the cycle out_last is accepted -> no input is accepted until the cycle after the out_last handshake; the second block emits correctly.
